// File: rtl/axis_merge_arbiter.sv
// Round-robin M_COUNT-to-1 AXI-Stream merge that strips per-channel all-ones end markers
// and emits one flush beat per frame. Optional marker payload check: AXIS_MERGE_MARKER_CHECK_EN.
module axis_merge_arbiter #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          merge_enable,
  output logic [M_COUNT-1:0]            s_axis_tready,
  input  logic [M_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [M_COUNT-1:0]            s_axis_tlast,
  input  logic [M_COUNT-1:0]            s_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  output logic                          marker_error
);
  localparam int                    PTR_W    = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam logic [PTR_W-1:0]      LAST_IDX = PTR_W'(M_COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tlast;
  logic                  r_tvalid;
  logic [M_COUNT-1:0]    r_done_mask;
  logic [PTR_W-1:0]      r_rr_ptr;

  logic                  w_slot_free;
  logic                  w_flush;
  logic                  w_grant_vld;
  logic [PTR_W-1:0]      w_grant_idx;
  logic [M_COUNT-1:0]    w_eligible;
  logic [DATA_WIDTH-1:0] w_grant_data;
  logic                  w_grant_last;
  logic                  w_is_marker;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return (sum >= M_COUNT) ? PTR_W'(sum - M_COUNT) : PTR_W'(sum);
  endfunction

  assign w_slot_free = !r_tvalid || m_axis_tready;
  // done_mask is registered, so the flush lands at least one cycle after the last marker
  assign w_flush     = (&r_done_mask) && w_slot_free;
  assign w_eligible  = s_axis_tvalid & ~r_done_mask;
  assign w_is_marker = merge_enable && w_grant_last;

  // Grant selection: first eligible channel at or after rr_ptr, or channel 0 in pass-through
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    if (rst || !w_slot_free || w_flush) begin
      w_grant_vld = 1'b0;
    end else if (!merge_enable) begin
      w_grant_vld = s_axis_tvalid[0];
    end else begin
      for (int k = 0; k < M_COUNT; k++) begin
        w_grant_idx = (!w_grant_vld && w_eligible[wrap_add(r_rr_ptr, k)]) ?
                      wrap_add(r_rr_ptr, k) : w_grant_idx;
        w_grant_vld = w_grant_vld || w_eligible[wrap_add(r_rr_ptr, k)];
      end
    end
  end

  // Granted-channel payload mux and one-hot ready
  always_comb begin
    w_grant_data  = '0;
    w_grant_last  = 1'b0;
    s_axis_tready = '0;
    for (int i = 0; i < M_COUNT; i++) begin
      w_grant_data     = (w_grant_idx == PTR_W'(i)) ? s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] : w_grant_data;
      w_grant_last     = (w_grant_idx == PTR_W'(i)) ? s_axis_tlast[i] : w_grant_last;
      s_axis_tready[i] = w_grant_vld && (w_grant_idx == PTR_W'(i));
    end
  end

  // Output register, marker bookkeeping and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata     <= '0;
      r_tlast     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_done_mask <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_flush) begin
        r_tdata     <= ALL_ONES;
        r_tlast     <= 1'b1;
        r_tvalid    <= 1'b1;
        r_done_mask <= '0;
      end else if (w_grant_vld && !w_is_marker) begin
        r_tdata  <= w_grant_data;
        r_tlast  <= w_grant_last;
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end else begin
        r_tvalid <= r_tvalid;
      end
      if (w_grant_vld && w_is_marker) begin
        r_done_mask[w_grant_idx] <= 1'b1;
      end
      if (w_grant_vld && merge_enable) begin
        r_rr_ptr <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + PTR_W'(1);
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;

`ifdef AXIS_MERGE_MARKER_CHECK_EN
  logic r_marker_error;

  function automatic logic is_all_ones(input logic [DATA_WIDTH-1:0] d);
    return d == ALL_ONES;
  endfunction

  // Sticky flag: a marker arrived whose payload is not all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_marker_error <= 1'b0;
    end else if (w_grant_vld && w_is_marker && !is_all_ones(w_grant_data)) begin
      r_marker_error <= 1'b1;
    end
  end

  assign marker_error = r_marker_error;
`else
  assign marker_error = 1'b0;
`endif

endmodule
